// File: rtl/led_cmd_pkg.sv
// Shared opcodes, FSM state encoding and pixel width for the LED command sequencer.
package led_cmd_pkg;

    localparam int unsigned PIX_W = 24;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_ADDR  = 8'h2A;
    localparam logic [7:0] OP_MEM_WRITE = 8'h2C;
    localparam logic [7:0] OP_REFRESH   = 8'h29;
    localparam logic [7:0] OP_SET_LEN   = 8'h2B;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR_HI = 3'd1;
    localparam logic [2:0] ST_ADDR_LO = 3'd2;
    localparam logic [2:0] ST_PIX     = 3'd3;
    localparam logic [2:0] ST_LEN_HI  = 3'd4;
    localparam logic [2:0] ST_LEN_LO  = 3'd5;
    localparam logic [2:0] ST_SKIP    = 3'd6;

endpackage

// File: rtl/led_pix_pack.sv
// Assembles three consecutive data bytes into one {G,R,B} pixel; first byte lands in the MSBs.
module led_pix_pack
    import led_cmd_pkg::*;
(
    input  logic             SCLK,
    input  logic             Rst,
    input  logic             clear,
    input  logic             byte_en,
    input  logic [7:0]       byte_data,
    output logic             done_c,
    output logic [PIX_W-1:0] pixel_c
);

    logic [1:0] phase;
    logic [7:0] b0;
    logic [7:0] b1;

    // Phase counter and holding registers for the first two bytes
    always_ff @(posedge SCLK) begin
        if (Rst || clear) begin
            phase <= 2'd0;
            b0    <= 8'h00;
            b1    <= 8'h00;
        end else if (byte_en) begin
            case (phase)
                2'd0: begin
                    b0    <= byte_data;
                    phase <= 2'd1;
                end
                2'd1: begin
                    b1    <= byte_data;
                    phase <= 2'd2;
                end
                default: phase <= 2'd0;
            endcase
        end
    end

    assign done_c  = byte_en && !clear && (phase == 2'd2);
    assign pixel_c = {b0, b1, byte_data};

endmodule

// File: rtl/led_cmd_ctrl.sv
// Command/data byte sequencer: pixel RAM writes, address pointer, refresh handshake.
// Define LED_CMD_CTRL_LEN_EN to accept SET_LEN (0x2B); otherwise led_len is fixed at DEPTH.
module led_cmd_ctrl
    import led_cmd_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              SCLK,
    input  logic              Rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_dc,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              refresh_req,
    input  logic              refresh_ack,
    output logic [15:0]       led_len,
    output logic              err
);

    localparam int unsigned VAL_W = 16;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        hi_byte;
    logic [VAL_W-1:0]  val_c;
    logic              cmd_c;
    logic              data_c;
    logic              addr_bad_c;
    logic              pix_clear;
    logic              pix_byte;
    logic              pix_done_c;
    logic [PIX_W-1:0]  pixel_c;
    logic              hi_ld;
    logic              addr_ld;
    logic              refresh_set;
    logic              err_nxt;
`ifdef LED_CMD_CTRL_LEN_EN
    logic              len_ld;
    logic              len_bad_c;
`endif

    assign cmd_c      = byte_valid & ~byte_dc;
    assign data_c     = byte_valid & byte_dc;
    assign val_c      = {hi_byte, byte_data};
    assign addr_bad_c = (17'(val_c) >= 17'(DEPTH));

    led_pix_pack u_pix_pack (
        .SCLK      (SCLK),
        .Rst       (Rst),
        .clear     (pix_clear),
        .byte_en   (pix_byte),
        .byte_data (byte_data),
        .done_c    (pix_done_c),
        .pixel_c   (pixel_c)
    );

    always_ff @(posedge SCLK) begin
        if (Rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and strobes; any command byte aborts the current sequence
    always_comb begin
        state_nxt   = state;
        pix_clear   = 1'b0;
        pix_byte    = 1'b0;
        hi_ld       = 1'b0;
        addr_ld     = 1'b0;
        refresh_set = 1'b0;
        err_nxt     = 1'b0;
`ifdef LED_CMD_CTRL_LEN_EN
        len_ld      = 1'b0;
`endif
        if (cmd_c) begin
            pix_clear = 1'b1;
            case (byte_data)
                OP_NOP:       state_nxt = ST_IDLE;
                OP_SET_ADDR:  state_nxt = ST_ADDR_HI;
                OP_MEM_WRITE: state_nxt = ST_PIX;
                OP_REFRESH: begin
                    state_nxt   = ST_IDLE;
                    refresh_set = 1'b1;
                end
`ifdef LED_CMD_CTRL_LEN_EN
                OP_SET_LEN:   state_nxt = ST_LEN_HI;
`endif
                default: begin
                    state_nxt = ST_SKIP;
                    err_nxt   = 1'b1;
                end
            endcase
        end else if (data_c) begin
            case (state)
                ST_ADDR_HI: begin
                    hi_ld     = 1'b1;
                    state_nxt = ST_ADDR_LO;
                end
                ST_ADDR_LO: begin
                    addr_ld   = 1'b1;
                    err_nxt   = addr_bad_c;
                    state_nxt = ST_IDLE;
                end
                ST_PIX:  pix_byte  = 1'b1;
                ST_SKIP: state_nxt = ST_SKIP;
`ifdef LED_CMD_CTRL_LEN_EN
                ST_LEN_HI: begin
                    hi_ld     = 1'b1;
                    state_nxt = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_ld    = 1'b1;
                    err_nxt   = len_bad_c;
                    state_nxt = ST_IDLE;
                end
`endif
                default: err_nxt = 1'b1;
            endcase
        end
    end

    // Pointer, RAM write port, refresh handshake and error pulse
    always_ff @(posedge SCLK) begin
        if (Rst) begin
            ptr         <= '0;
            hi_byte     <= 8'h00;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            refresh_req <= 1'b0;
            err         <= 1'b0;
        end else begin
            ram_we <= pix_done_c;
            err    <= err_nxt;
            if (hi_ld) hi_byte <= byte_data;
            if (pix_done_c) begin
                ram_addr  <= ptr;
                ram_wdata <= pixel_c;
                ptr       <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
            end else if (addr_ld) begin
                ptr <= addr_bad_c ? '0 : ADDR_W'(val_c);
            end
            if (refresh_set)      refresh_req <= 1'b1;
            else if (refresh_ack) refresh_req <= 1'b0;
        end
    end

`ifdef LED_CMD_CTRL_LEN_EN
    assign len_bad_c = (val_c == '0) || (17'(val_c) > 17'(DEPTH));

    always_ff @(posedge SCLK) begin
        if (Rst)         led_len <= 16'(DEPTH);
        else if (len_ld) led_len <= len_bad_c ? 16'(DEPTH) : val_c;
    end
`else
    assign led_len = 16'(DEPTH);
`endif

endmodule
